set_err_mgr: RTL and testbench



---
 rtl/set_err_pkg.sv | 19 +
 rtl/set_err_satcnt.sv | 37 +++
 rtl/set_err_mgr.sv | 147 ++++++++++++++
 tb/tb_set_err_mgr.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/set_err_pkg.sv
// rtl/set_err_pkg.sv - shared types and helpers for the SET error manager
package set_err_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MONITOR = 2'd1,
        PERM    = 2'd2
    } err_state_t;

    localparam int ST_W = 2;

    // Increment that sticks at the all-ones value of a width-bit field.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_v;
        max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_v) ? max_v : value + 32'd1;
    endfunction

endpackage

// File: rtl/set_err_satcnt.sv
// rtl/set_err_satcnt.sv - saturating event counter with synchronous clear
module set_err_satcnt
    import set_err_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear together with inc restarts the count at one.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = inc_i ? W'(1) : '0;
        end else if (inc_i) begin
            cnt_d = W'(sat_inc(32'(cnt_q), W));
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/set_err_mgr.sv
// rtl/set_err_mgr.sv - masks, counts and classifies detector error events
module set_err_mgr
    import set_err_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int CNT_W = 8,
    parameter int WIN_W = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [N_SRC-1:0] err_i,
    input  logic [N_SRC-1:0] mask_i,
    input  logic [WIN_W-1:0] window_i,
    input  logic [CNT_W-1:0] thresh_i,
    input  logic             clr_req_i,
    output logic             clr_ack_o,
    output logic             irq_trans_o,
    output logic             irq_perm_o,
    output logic [N_SRC-1:0] err_src_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [ST_W-1:0]  state_o
);

    logic [N_SRC-1:0] hit;
    logic             ev;
    logic             clr_go;

    err_state_t       state_q, state_d;
    logic [WIN_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] thr_q, thr_d;
    logic             ack_q, ack_d;
    logic             irq_t_q, irq_t_d;
    logic             irq_p_q, irq_p_d;
    logic [N_SRC-1:0] src_q, src_d;

    logic             wcnt_clr, wcnt_inc;
    logic [CNT_W-1:0] wcnt, wcnt_new;

    assign hit    = err_i & ~mask_i;
    assign ev     = |hit;
    assign clr_go = clr_req_i && !ack_q;

    // Window count as it would stand after this cycle's event, for the threshold test.
    assign wcnt_new = ev ? CNT_W'(sat_inc(32'(wcnt), CNT_W)) : wcnt;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        thr_d    = thr_q;
        ack_d    = ack_q;
        irq_t_d  = irq_t_q;
        irq_p_d  = irq_p_q;
        src_d    = src_q | hit;
        wcnt_clr = 1'b0;
        wcnt_inc = 1'b0;
        if (clr_go) begin
            ack_d    = 1'b1;
            state_d  = IDLE;
            timer_d  = '0;
            thr_d    = '0;
            irq_t_d  = 1'b0;
            irq_p_d  = 1'b0;
            src_d    = '0;
            wcnt_clr = 1'b1;
        end else begin
            if (ack_q && !clr_req_i) begin
                ack_d = 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (ev) begin
                        timer_d  = (window_i == '0) ? '0 : window_i - WIN_W'(1);
                        thr_d    = thresh_i;
                        wcnt_clr = 1'b1;
                        wcnt_inc = 1'b1;
                        if (thresh_i == CNT_W'(1)) begin
                            state_d = PERM;
                            irq_p_d = 1'b1;
                        end else begin
                            state_d = MONITOR;
                        end
                    end
                end
                MONITOR: begin
                    wcnt_inc = ev;
                    if (thr_q != '0 && wcnt_new >= thr_q) begin
                        state_d = PERM;
                        irq_p_d = 1'b1;
                    end else if (timer_q == '0) begin
                        state_d  = IDLE;
                        irq_t_d  = 1'b1;
                        wcnt_clr = 1'b1;
                        wcnt_inc = 1'b0;
                    end else begin
                        timer_d = timer_q - WIN_W'(1);
                    end
                end
                PERM: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            timer_q <= '0;
            thr_q   <= '0;
            ack_q   <= 1'b0;
            irq_t_q <= 1'b0;
            irq_p_q <= 1'b0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            thr_q   <= thr_d;
            ack_q   <= ack_d;
            irq_t_q <= irq_t_d;
            irq_p_q <= irq_p_d;
            src_q   <= src_d;
        end
    end

    set_err_satcnt #(.W(CNT_W)) u_err_cnt (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr_i  (clr_go),
        .inc_i  (ev && !clr_go),
        .cnt_o  (err_cnt_o)
    );

    set_err_satcnt #(.W(CNT_W)) u_wcnt (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr_i  (wcnt_clr),
        .inc_i  (wcnt_inc),
        .cnt_o  (wcnt)
    );

    assign clr_ack_o   = ack_q;
    assign irq_trans_o = irq_t_q;
    assign irq_perm_o  = irq_p_q;
    assign err_src_o   = src_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_set_err_mgr.sv
// tb/tb_set_err_mgr.sv - directed scoreboard bench for set_err_mgr
module tb_set_err_mgr;

    logic       clk;
    logic       rstn;
    logic [3:0] err;
    logic [3:0] mask;
    logic [15:0] window;
    logic [7:0] thresh;
    logic       clr_req;
    logic       clr_ack;
    logic       irq_trans;
    logic       irq_perm;
    logic [3:0] err_src;
    logic [7:0] err_cnt;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic       ack;
        logic       trans;
        logic       perm;
        logic [3:0] src;
        logic [7:0] cnt;
        logic [1:0] st;
    } exp_t;

    exp_t sb[$];

    set_err_mgr #(.N_SRC(4), .CNT_W(8), .WIN_W(16)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .err_i       (err),
        .mask_i      (mask),
        .window_i    (window),
        .thresh_i    (thresh),
        .clr_req_i   (clr_req),
        .clr_ack_o   (clr_ack),
        .irq_trans_o (irq_trans),
        .irq_perm_o  (irq_perm),
        .err_src_o   (err_src),
        .err_cnt_o   (err_cnt),
        .state_o     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic expect_out(input string tag, input logic ack, input logic trans, input logic perm,
                              input logic [3:0] src, input logic [7:0] cnt, input logic [1:0] st);
        exp_t e;
        e.tag = tag; e.ack = ack; e.trans = trans; e.perm = perm;
        e.src = src; e.cnt = cnt; e.st = st;
        sb.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".ack"},   32'(clr_ack),   32'(e.ack));
            chk({e.tag, ".trans"}, 32'(irq_trans), 32'(e.trans));
            chk({e.tag, ".perm"},  32'(irq_perm),  32'(e.perm));
            chk({e.tag, ".src"},   32'(err_src),   32'(e.src));
            chk({e.tag, ".cnt"},   32'(err_cnt),   32'(e.cnt));
            chk({e.tag, ".state"}, 32'(state),     32'(e.st));
        end
    endtask

    task automatic do_clear(input string tag);
        clr_req = 1'b1;
        expect_out({tag, "_ack"}, 1'b1, 1'b0, 1'b0, 4'h0, 8'd0, 2'd0);
        tick();
        compare_out();
        clr_req = 1'b0;
        expect_out({tag, "_rel"}, 1'b0, 1'b0, 1'b0, 4'h0, 8'd0, 2'd0);
        tick();
        compare_out();
    endtask

    initial begin
        rstn = 1'b0; err = '0; mask = '0; window = 16'd10; thresh = 8'd3; clr_req = 1'b0;
        repeat (2) tick();
        expect_out("reset", 1'b0, 1'b0, 1'b0, 4'h0, 8'd0, 2'd0);
        compare_out();
        rstn = 1'b1;
        tick();

        // Isolated pulse: transient after the full window.
        err = 4'b0010;
        expect_out("pulse_e0", 1'b0, 1'b0, 1'b0, 4'b0010, 8'd1, 2'd1);
        tick();
        compare_out();
        err = '0;
        repeat (8) tick();
        expect_out("pulse_e9", 1'b0, 1'b0, 1'b0, 4'b0010, 8'd1, 2'd1);
        tick();
        compare_out();
        expect_out("pulse_e10", 1'b0, 1'b1, 1'b0, 4'b0010, 8'd1, 2'd0);
        tick();
        compare_out();
        do_clear("clr1");

        // Burst of three events inside the window: permanent.
        for (int i = 0; i < 8; i++) begin
            err = (i == 0 || i == 4 || i == 7) ? 4'b0001 : 4'b0000;
            if (i == 6) expect_out("burst_e6", 1'b0, 1'b0, 1'b0, 4'b0001, 8'd2, 2'd1);
            if (i == 7) expect_out("burst_e7", 1'b0, 1'b0, 1'b1, 4'b0001, 8'd3, 2'd2);
            tick();
            if (i >= 6) compare_out();
        end
        err = 4'b0001;
        expect_out("perm_cnt4", 1'b0, 1'b0, 1'b1, 4'b0001, 8'd4, 2'd2);
        tick();
        compare_out();
        expect_out("perm_cnt5", 1'b0, 1'b0, 1'b1, 4'b0001, 8'd5, 2'd2);
        tick();
        compare_out();

        // Clear collides with an event in PERM; held request is not re-accepted.
        clr_req = 1'b1; err = 4'b0100;
        expect_out("coll_clr", 1'b1, 1'b0, 1'b0, 4'h0, 8'd0, 2'd0);
        tick();
        compare_out();
        expect_out("coll_hold", 1'b1, 1'b0, 1'b0, 4'b0100, 8'd1, 2'd1);
        tick();
        compare_out();
        clr_req = 1'b0; err = '0;
        expect_out("coll_rel", 1'b0, 1'b0, 1'b0, 4'b0100, 8'd1, 2'd1);
        tick();
        compare_out();
        do_clear("clr2");

        // Masked source is invisible; an unmasked one still registers.
        mask = 4'b0001; err = 4'b0001;
        for (int i = 0; i < 20; i++) expect_out("mask_quiet", 1'b0, 1'b0, 1'b0, 4'h0, 8'd0, 2'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            compare_out();
        end
        err = 4'b0011;
        expect_out("mask_pass", 1'b0, 1'b0, 1'b0, 4'b0010, 8'd1, 2'd1);
        tick();
        compare_out();
        err = '0; mask = '0;
        do_clear("clr3");

        // Threshold of one goes straight to PERM.
        thresh = 8'd1; err = 4'b1000;
        expect_out("thr1", 1'b0, 1'b0, 1'b1, 4'b1000, 8'd1, 2'd2);
        tick();
        compare_out();
        err = '0;
        do_clear("clr4");

        // Zero window behaves as a one-cycle window.
        thresh = 8'd3; window = 16'd0; err = 4'b0001;
        expect_out("win0_e0", 1'b0, 1'b0, 1'b0, 4'b0001, 8'd1, 2'd1);
        tick();
        compare_out();
        err = '0;
        expect_out("win0_e1", 1'b0, 1'b1, 1'b0, 4'b0001, 8'd1, 2'd0);
        tick();
        compare_out();
        do_clear("clr5");

        // Held source with classification disabled: counter saturates, windows keep expiring.
        thresh = 8'd0; window = 16'd10; err = 4'b0001;
        for (int i = 0; i < 300; i++) begin
            if (i == 0)   expect_out("sat_e0",   1'b0, 1'b0, 1'b0, 4'b0001, 8'd1,   2'd1);
            if (i == 9)   expect_out("sat_e9",   1'b0, 1'b0, 1'b0, 4'b0001, 8'd10,  2'd1);
            if (i == 10)  expect_out("sat_e10",  1'b0, 1'b1, 1'b0, 4'b0001, 8'd11,  2'd0);
            if (i == 11)  expect_out("sat_e11",  1'b0, 1'b1, 1'b0, 4'b0001, 8'd12,  2'd1);
            if (i == 254) expect_out("sat_e254", 1'b0, 1'b1, 1'b0, 4'b0001, 8'd255, 2'd1);
            if (i == 299) expect_out("sat_e299", 1'b0, 1'b1, 1'b0, 4'b0001, 8'd255, 2'd1);
            tick();
            if (i == 0 || i == 9 || i == 10 || i == 11 || i == 254 || i == 299) compare_out();
        end
        err = '0;
        do_clear("clr6");

        // Maximum threshold reached just as the window counter hits all-ones.
        thresh = 8'd255; window = 16'd1000; err = 4'b0010;
        for (int i = 0; i < 257; i++) begin
            if (i == 253) expect_out("thrmax_e253", 1'b0, 1'b0, 1'b0, 4'b0010, 8'd254, 2'd1);
            if (i == 254) expect_out("thrmax_e254", 1'b0, 1'b0, 1'b1, 4'b0010, 8'd255, 2'd2);
            if (i == 256) expect_out("thrmax_e256", 1'b0, 1'b0, 1'b1, 4'b0010, 8'd255, 2'd2);
            tick();
            if (i == 253 || i == 254 || i == 256) compare_out();
        end
        err = '0;
        do_clear("clr7");

        // Asynchronous reset in the middle of a window, then a fresh full window.
        thresh = 8'd3; window = 16'd10; err = 4'b0001;
        tick();
        err = '0;
        repeat (2) tick();
        #2 rstn = 1'b0;
        #1;
        expect_out("async_rst", 1'b0, 1'b0, 1'b0, 4'h0, 8'd0, 2'd0);
        compare_out();
        rstn = 1'b1;
        tick();
        err = 4'b0010;
        expect_out("rst_e0", 1'b0, 1'b0, 1'b0, 4'b0010, 8'd1, 2'd1);
        tick();
        compare_out();
        err = '0;
        repeat (8) tick();
        expect_out("rst_e9", 1'b0, 1'b0, 1'b0, 4'b0010, 8'd1, 2'd1);
        tick();
        compare_out();
        expect_out("rst_e10", 1'b0, 1'b1, 1'b0, 4'b0010, 8'd1, 2'd0);
        tick();
        compare_out();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
